button_conditioner: RTL

Front-end conditioner for the three push-buttons that drive the counter state machine. Each raw, asynchronous, bouncing button input is synchronized to `clk_100MHz`, debounced with a stability counter, and converted to a single-cycle rising-edge pulse. The pulses `start`, `progressive` and `regressive` connect directly to the state machine's inputs of the same names. Each press yields exactly one pulse, and a progressive/regressive conflict is resolved before it reaches the state machine.

---
 rtl/button_pkg.sv | 10 +
 rtl/debounce_channel.sv | 38 +++
 rtl/button_conditioner.sv | 46 ++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared constants for the push-button front end: debounce lengths and channel slots.
package button_pkg;
  localparam int STABLE_CYCLES_DEFAULT = 1_000_000;
  localparam int STABLE_CYCLES_SIM     = 4;

  localparam int BTN_START = 0;
  localparam int BTN_PROG  = 1;
  localparam int BTN_REG   = 2;
  localparam int NUM_BTN   = 3;
endpackage

// File: rtl/debounce_channel.sv
// One button path: 2-flop synchronizer, stability counter with debounced level,
// and a rise strobe that is high in the cycle whose edge takes the level 0->1.
module debounce_channel
  import button_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(STABLE_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          done;

  assign differ = sync[1] ^ level;
  assign done   = differ && (cnt == CW'(STABLE_CYCLES - 1));
  // Registered at the top level, so the output pulse lands on the same edge as the level.
  assign rise   = done & ~level;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (!differ || done) cnt <= '0;
      else                 cnt <= cnt + CW'(1);
      if (done) level <= ~level;
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// Three debounced button channels feeding registered one-cycle press pulses;
// a progressive press wins over a simultaneous regressive press.
module button_conditioner
  import button_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_progressive,
  input  logic       btn_regressive,
  output logic       start,
  output logic       progressive,
  output logic       regressive,
  output logic [2:0] level
);
  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] rise;

  assign raw[BTN_START] = btn_start;
  assign raw[BTN_PROG]  = btn_progressive;
  assign raw[BTN_REG]   = btn_regressive;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch (
      .clk_100MHz(clk_100MHz),
      .reset     (reset),
      .raw       (raw[i]),
      .level     (level[i]),
      .rise      (rise[i])
    );
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      start       <= 1'b0;
      progressive <= 1'b0;
      regressive  <= 1'b0;
    end else begin
      start       <= rise[BTN_START];
      progressive <= rise[BTN_PROG];
      regressive  <= rise[BTN_REG] & ~rise[BTN_PROG];
    end
  end
endmodule
